// File: rtl/sram_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_seq_pkg
// Description : Shared types and constants for the SRAM sequencing controller.
//               Holds the controller state encoding and the read-side
//               encoding (Q side via wl, QB side via wlb).
// Revision    : 1.0 - initial release
// ============================================================================
package sram_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        ACCESS = 3'd2,
        SENSE  = 3'd3,
        PRE    = 3'd4,
        RESP   = 3'd5
    } state_t;

    localparam logic SIDE_Q  = 1'b0;
    localparam logic SIDE_QB = 1'b1;

endpackage : sram_seq_pkg
`default_nettype wire

// File: rtl/sram_row_decode.sv
`default_nettype none
// ============================================================================
// Module      : sram_row_decode
// Description : One-hot word-line decoder. Produces a ROWS-wide one-hot
//               vector for an in-range address when enabled; all zeros when
//               disabled or when the address is beyond the last row.
// Ports       : i_addr [ADDR_W] row address
//               i_en            decoder enable
//               o_row  [ROWS]   one-hot row select
// Revision    : 1.0 - initial release
// ============================================================================
module sram_row_decode #(
    parameter int ROWS   = 4,
    parameter int ADDR_W = 2
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_en,
    output logic [ROWS-1:0]   o_row
);

    // Only indices 0..ROWS-1 are compared, so an out-of-range address
    // matches nothing and the output stays all zeros.
    always_comb begin
        o_row = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (i_en && (32'(i_addr) == 32'(i))) begin
                o_row[i] = 1'b1;
            end
        end
    end

endmodule : sram_row_decode
`default_nettype wire

// File: rtl/sram_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_seq_ctrl
// Description : Sequencer for a small 6T-style SRAM array. Accepts one
//               read / write / write-verify request at a time and drives
//               precharge, word lines, write drivers and sense amps through
//               timed phases, returning a single-cycle response for reads,
//               verifies and bad addresses.
// Ports       : clk, rst (async, active high)
//               req_valid/req_ready handshake; req_we, req_side, req_verify,
//               req_addr, req_wdata request fields
//               preb, w_en, write_bit, sae, wl, wlb, sense_in array interface
//               rsp_valid, rsp_data, rsp_err response
// Revision    : 1.0 - initial release
// ============================================================================
module sram_seq_ctrl
    import sram_seq_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ROWS    = 4,
    parameter int PRE_CYC = 1,
    parameter int WR_CYC  = 2,
    parameter int RD_CYC  = 2,
    localparam int ADDR_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_side,
    input  logic              req_verify,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              preb,
    output logic              w_en,
    output logic [DATA_W-1:0] write_bit,
    output logic              sae,
    output logic [ROWS-1:0]   wl,
    output logic [ROWS-1:0]   wlb,
    input  logic [DATA_W-1:0] sense_in,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    localparam int MAX_WR_RD = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
    localparam int MAX_CYC   = (PRE_CYC > MAX_WR_RD) ? PRE_CYC : MAX_WR_RD;
    localparam int CNT_W     = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] PRE_LD = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LD  = CNT_W'(WR_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LD  = CNT_W'(RD_CYC - 1);

    state_t              r_state;
    state_t              w_nstate;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_live;      // set on the first edge after reset release
    logic                r_we;
    logic                r_side;
    logic                r_verify;
    logic                r_rd_done;   // a sense phase has completed for this request
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_cap;

    logic                w_accept;
    logic                w_req_ok;
    logic                w_side;
    logic [DATA_W-1:0]   w_sensed;
    logic                w_wl_en;
    logic                w_wlb_en;

    assign w_req_ok = (32'(req_addr) < 32'(ROWS));

    // The read-back of a verify always uses the Q side.
    assign w_side   = r_we ? SIDE_Q : r_side;
    assign w_sensed = (w_side == SIDE_QB) ? ~sense_in : sense_in;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_cnt_nxt;
            r_live  <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next state, phase counter and array controls
    // ------------------------------------------------------------------
    always_comb begin
        w_nstate  = r_state;
        w_cnt_nxt = r_cnt;
        w_accept  = 1'b0;
        req_ready = 1'b0;
        preb      = 1'b0;
        w_en      = 1'b0;
        sae       = 1'b0;
        rsp_valid = 1'b0;
        write_bit = '0;
        w_wl_en   = 1'b0;
        w_wlb_en  = 1'b0;

        case (r_state)
            IDLE: begin
                req_ready = r_live;
                if (req_valid && r_live) begin
                    w_accept = 1'b1;
                    if (!w_req_ok) begin
                        w_nstate = RESP;
                    end else if (req_we) begin
                        w_nstate  = WRITE;
                        w_cnt_nxt = WR_LD;
                    end else begin
                        w_nstate  = ACCESS;
                        w_cnt_nxt = RD_LD;
                    end
                end
            end
            WRITE: begin
                preb      = 1'b1;
                w_en      = 1'b1;
                write_bit = r_wdata;
                w_wl_en   = 1'b1;
                w_wlb_en  = 1'b1;
                if (r_cnt == '0) begin
                    w_nstate  = PRE;
                    w_cnt_nxt = PRE_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ACCESS: begin
                preb     = 1'b1;
                w_wl_en  = (w_side == SIDE_Q);
                w_wlb_en = (w_side == SIDE_QB);
                if (r_cnt == '0) begin
                    w_nstate = SENSE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            SENSE: begin
                preb      = 1'b1;
                sae       = 1'b1;
                w_wl_en   = (w_side == SIDE_Q);
                w_wlb_en  = (w_side == SIDE_QB);
                w_nstate  = PRE;
                w_cnt_nxt = PRE_LD;
            end
            PRE: begin
                if (r_cnt == '0) begin
                    if (r_rd_done) begin
                        w_nstate = RESP;
                    end else if (r_verify) begin
                        w_nstate  = ACCESS;
                        w_cnt_nxt = RD_LD;
                    end else begin
                        w_nstate = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                w_nstate  = IDLE;
            end
            default: begin
                w_nstate = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, sense capture and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we      <= 1'b0;
            r_side    <= SIDE_Q;
            r_verify  <= 1'b0;
            r_rd_done <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cap     <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we      <= req_we;
                r_side    <= req_side;
                r_verify  <= req_we & req_verify;
                r_addr    <= req_addr;
                r_wdata   <= req_wdata;
                r_rd_done <= 1'b0;
            end
            if (r_state == SENSE) begin
                r_cap     <= w_sensed;
                r_rd_done <= 1'b1;
            end
            // Response fields update only on entry to RESP and hold otherwise.
            if ((w_nstate == RESP) && (r_state != RESP)) begin
                if (r_state == IDLE) begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end else begin
                    rsp_data <= r_cap;
                    rsp_err  <= r_verify && (r_cap != r_wdata);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Word-line decoders
    // ------------------------------------------------------------------
    sram_row_decode #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_dec_wl (
        .i_addr (r_addr),
        .i_en   (w_wl_en),
        .o_row  (wl)
    );

    sram_row_decode #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_dec_wlb (
        .i_addr (r_addr),
        .i_en   (w_wlb_en),
        .o_row  (wlb)
    );

endmodule : sram_seq_ctrl
`default_nettype wire

// File: tb/tb_sram_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_seq_ctrl
// Description : Directed, table-driven bench for sram_seq_ctrl (defaults)
//               plus a ROWS=3 instance for the bad-address path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_seq_ctrl;

    typedef struct {
        logic       we;
        logic       side;
        logic       verify;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] sense;
        logic       exp_rsp;
        logic [7:0] exp_data;
        logic       exp_err;
        logic [3:0] exp_wl;
        logic [3:0] exp_wlb;
        int         exp_n;     // edges from acceptance until req_ready seen again
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       req_valid = 1'b0, req_we = 1'b0, req_side = 1'b0, req_verify = 1'b0;
    logic [1:0] req_addr = '0;
    logic [7:0] req_wdata = '0, sense_in = '0;
    logic       req_ready, preb, w_en, sae, rsp_valid, rsp_err;
    logic [7:0] write_bit, rsp_data;
    logic [3:0] wl, wlb;

    logic       d3_valid = 1'b0;
    logic [1:0] d3_addr = '0;
    logic       d3_ready, d3_preb, d3_wen, d3_sae, d3_rsp_valid, d3_rsp_err;
    logic [7:0] d3_write_bit, d3_rsp_data;
    logic [2:0] d3_wl, d3_wlb;

    int n_cmp  = 0;
    int n_fail = 0;
    int viol   = 0;

    always #5 clk = ~clk;

    sram_seq_ctrl u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_side(req_side), .req_verify(req_verify), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .preb(preb), .w_en(w_en), .write_bit(write_bit), .sae(sae),
        .wl(wl), .wlb(wlb), .sense_in(sense_in),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    sram_seq_ctrl #(.ROWS(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(d3_valid), .req_ready(d3_ready), .req_we(1'b0),
        .req_side(1'b0), .req_verify(1'b0), .req_addr(d3_addr),
        .req_wdata(8'h00),
        .preb(d3_preb), .w_en(d3_wen), .write_bit(d3_write_bit), .sae(d3_sae),
        .wl(d3_wl), .wlb(d3_wlb), .sense_in(8'hFF),
        .rsp_valid(d3_rsp_valid), .rsp_data(d3_rsp_data), .rsp_err(d3_rsp_err)
    );

    // Array-safety invariants, checked every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            if ($countones(wl) > 1 || $countones(wlb) > 1 || (w_en && sae))
                viol++;
            if (d3_wl != 3'b000 || d3_wlb != 3'b000 || d3_wen)
                viol++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int         n;
        int         rsp_n;
        int         wb_bad;
        logic [3:0] wlo, wlbo;
        logic [7:0] gd;
        logic       ge;
        n = 0; rsp_n = 0; wb_bad = 0; wlo = '0; wlbo = '0; gd = '0; ge = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_side = v.side; req_verify = v.verify;
        req_addr = v.addr; req_wdata = v.wdata; sense_in = v.sense;
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        n = 1;
        // Scramble the request fields after acceptance; they must be ignored.
        req_valid = 1'b0; req_we = ~v.we; req_side = ~v.side; req_verify = ~v.verify;
        req_addr = v.addr + 2'd1; req_wdata = ~v.wdata;
        forever begin
            wlo  |= wl;
            wlbo |= wlb;
            if (rsp_valid) begin rsp_n++; gd = rsp_data; ge = rsp_err; end
            if (w_en && write_bit !== v.wdata) wb_bad++;
            if (req_ready || n >= 40) break;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(v.exp_n));
        chk({tag, "_wl"}, 32'(wlo), 32'(v.exp_wl));
        chk({tag, "_wlb"}, 32'(wlbo), 32'(v.exp_wlb));
        chk({tag, "_rsp_count"}, 32'(rsp_n), v.exp_rsp ? 32'd1 : 32'd0);
        chk({tag, "_write_bit"}, 32'(wb_bad), 32'd0);
        if (v.exp_rsp) begin
            chk({tag, "_rsp_data"}, 32'(gd), 32'(v.exp_data));
            chk({tag, "_rsp_err"}, 32'(ge), 32'(v.exp_err));
        end
    endtask

    vec_t vecs[7];

    initial begin
        int         n;
        int         seen;
        logic [2:0] d3_or;
        vec_t       rv;

        //            we side ver addr wdata  sense rsp data   err wl       wlb      n
        vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd2, 8'hA5, 8'h00, 1'b0, 8'h00, 1'b0, 4'b0100, 4'b0100, 4};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 2'd1, 8'h00, 8'h5A, 1'b1, 8'hA5, 1'b0, 4'b0000, 4'b0010, 6};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 2'd3, 8'h0F, 8'h0E, 1'b1, 8'h0E, 1'b1, 4'b1000, 4'b1000, 9};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h3C, 1'b1, 8'h3C, 1'b0, 4'b0001, 4'b0000, 6};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 2'd1, 8'hC3, 8'hC3, 1'b1, 8'hC3, 1'b0, 4'b0010, 4'b0010, 9};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 2'd3, 8'h00, 8'h0F, 1'b1, 8'hF0, 1'b0, 4'b0000, 4'b1000, 6};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 2'd0, 8'hFF, 8'h77, 1'b0, 8'h00, 1'b0, 4'b0001, 4'b0001, 4};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_preb", 32'(preb), 32'd0);
        chk("rst_wl_wlb", 32'({wl, wlb}), 32'd0);
        chk("rst_en_sae", 32'({w_en, sae, rsp_valid}), 32'd0);
        chk("rst_rsp", 32'({rsp_err, rsp_data, write_bit}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // Directed table
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));
        chk("rsp_hold", 32'({rsp_err, rsp_data}), 32'h0F0);

        // Random reads with model-computed expectations
        for (int k = 0; k < 8; k++) begin
            rv.we = 1'b0; rv.verify = 1'b0; rv.wdata = 8'h00;
            rv.side  = 1'($urandom_range(0, 1));
            rv.addr  = 2'($urandom_range(0, 3));
            rv.sense = 8'($urandom_range(0, 255));
            rv.exp_rsp  = 1'b1;
            rv.exp_data = rv.side ? ~rv.sense : rv.sense;
            rv.exp_err  = 1'b0;
            rv.exp_wl   = rv.side ? 4'b0000 : (4'b0001 << rv.addr);
            rv.exp_wlb  = rv.side ? (4'b0001 << rv.addr) : 4'b0000;
            rv.exp_n    = 6;
            run_vec(rv, $sformatf("rnd%0d", k));
        end

        // Bad address on the ROWS=3 instance
        @(negedge clk);
        d3_valid = 1'b1; d3_addr = 2'd3;
        chk("bad_ready", 32'(d3_ready), 32'd1);
        @(posedge clk); #1;
        d3_valid = 1'b0; d3_addr = 2'd0;
        chk("bad_rsp_valid", 32'(d3_rsp_valid), 32'd1);
        chk("bad_rsp_err", 32'(d3_rsp_err), 32'd1);
        chk("bad_rsp_data", 32'(d3_rsp_data), 32'd0);
        d3_or = d3_wl | d3_wlb;
        @(posedge clk); #1;
        d3_or |= d3_wl | d3_wlb;
        chk("bad_wordlines", 32'(d3_or), 32'd0);
        chk("bad_back_idle", 32'({d3_ready, d3_rsp_valid}), 32'b10);

        // Reset during ACCESS
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_side = 1'b0; req_verify = 1'b0;
        req_addr = 2'd2; sense_in = 8'h11;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_wl_before", 32'(wl), 32'h4);
        #1 rst = 1'b1;
        #1;
        chk("mid_wl_drop", 32'({wl, wlb}), 32'd0);
        chk("mid_ready_low", 32'(req_ready), 32'd0);
        seen = 0;
        repeat (2) begin @(posedge clk); #1; if (rsp_valid) seen++; end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_ready_release", 32'(req_ready), 32'd1);
        n = 0;
        while (n < 8) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
            n++;
        end
        chk("mid_no_rsp", 32'(seen), 32'd0);

        chk("invariants", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_sram_seq_ctrl
`default_nettype wire

// File: doc/sram_seq_ctrl.md
SRAM_SEQ_CTRL -- requirements
Module: sram_seq_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the word width in bits.
REQ-002 Parameter ROWS, default 4, SHALL set the number of word lines; ADDR_W = max(1, $clog2(ROWS)).
REQ-003 Parameters PRE_CYC, WR_CYC and RD_CYC, defaults 1, 2 and 2, each >= 1, SHALL set the precharge, write-drive and read-develop phase lengths in clk cycles.
REQ-004 Ports: clk  in  1  rising-edge clock; rst  in  1  reset, asynchronous and active-high.
REQ-005 Request ports: req_valid  in  1  request present; req_ready  out  1  request accepted when high with req_valid; req_we  in  1  1=write, 0=read.
REQ-006 Request ports: req_side  in  1  read side, 0=Q via wl, 1=QB via wlb; req_verify  in  1  write followed by read-back compare; req_addr  in  ADDR_W  row; req_wdata  in  DATA_W  write data.
REQ-007 Array ports: preb  out  1  bitline precharge, active low; w_en  out  1  write driver enable; write_bit  out  DATA_W  driven data; sae  out  1  sense-amp enable.
REQ-008 Array ports: wl  out  ROWS  one-hot Q-side word lines; wlb  out  ROWS  one-hot QB-side word lines; sense_in  in  DATA_W  sense-amp output.
REQ-009 Response ports: rsp_valid  out  1  single-cycle pulse; rsp_data  out  DATA_W  read data, true polarity; rsp_err  out  1  verify mismatch or bad address.

Function
REQ-010 The FSM SHALL have the states IDLE, WRITE, ACCESS, SENSE, PRE and RESP.
REQ-011 In IDLE, req_ready SHALL be 1, preb 0, and w_en, sae, wl and wlb all 0; in every other state req_ready SHALL be 0.
REQ-012 The block SHALL register req_we, req_side, req_verify, req_addr and req_wdata on acceptance; later changes on the request inputs SHALL have no effect.
REQ-013 An accepted write SHALL enter WRITE for exactly WR_CYC cycles with preb=1, w_en=1, wl[addr]=1, wlb[addr]=1 and write_bit equal to the registered wdata.
REQ-014 An accepted read SHALL enter ACCESS for exactly RD_CYC cycles with preb=1 and only wl[addr] (side 0) or only wlb[addr] (side 1) high.
REQ-015 SENSE SHALL last exactly 1 cycle with the same word-line state as ACCESS and sae=1; sense_in SHALL be captured at the end of SENSE.
REQ-016 Captured data SHALL be sense_in for side 0 and ~sense_in for side 1.
REQ-017 PRE SHALL follow WRITE or SENSE and last exactly PRE_CYC cycles with preb=0 and all word lines, w_en and sae at 0.
REQ-018 A write with verify SHALL go WRITE -> PRE -> ACCESS (side 0) -> SENSE -> PRE -> RESP, with rsp_err = (captured != wdata) and rsp_data = captured data.
REQ-019 A write without verify SHALL go WRITE -> PRE -> IDLE with no response.
REQ-020 A read SHALL go ACCESS -> SENSE -> PRE -> RESP.
REQ-021 RESP SHALL last 1 cycle with rsp_valid=1, then the FSM SHALL return to IDLE; rsp_data and rsp_err SHALL hold until the next response.
REQ-022 A request with addr >= ROWS SHALL be accepted, SHALL assert no word line and no w_en, and SHALL go directly to RESP with rsp_err=1 and rsp_data=0.
REQ-023 At most one wl bit and one wlb bit SHALL be high in any cycle, and w_en SHALL never be 1 in the same cycle as sae.
REQ-024 The minimum back-to-back request spacing (read) SHALL be 1+RD_CYC+1+PRE_CYC+1 cycles from acceptance to the next req_ready.

Reset
REQ-025 While rst=1, asynchronously: state=IDLE; preb, w_en, sae, wl, wlb, write_bit, rsp_valid, rsp_data, rsp_err and the phase counter all 0; req_ready=0.
REQ-026 req_ready SHALL rise in the first cycle after rst is released.
REQ-027 Reset asserted mid-operation SHALL drop all word lines in the same cycle and emit no response.

Structure
REQ-028 Package sram_seq_pkg SHALL hold the state enum and the side encoding constants (SIDE_Q=0, SIDE_QB=1).
REQ-029 Sub-module sram_row_decode SHALL produce a one-hot ROWS-wide output from addr and enable, with all zeros for an out-of-range address.
REQ-030 A single down-counter of width $clog2(max(PRE_CYC,WR_CYC,RD_CYC)+1) SHALL time all phases.

Verification (DATA_W=8, ROWS=4, defaults)
REQ-031 Write addr=2 wdata=0xA5 -> wl=wlb=4'b0100, w_en=1, write_bit=0xA5 for 2 cycles, then preb=0 for 1 cycle, then req_ready=1; no rsp_valid.
REQ-032 Read addr=1 side=1 with sense_in=0x5A -> wlb=4'b0010 for 3 cycles, sae=1 in the 3rd, then rsp_valid with rsp_data=0xA5 and rsp_err=0.
REQ-033 Write-verify addr=3 wdata=0x0F with sense_in=0x0E -> the read phase uses wl=4'b1000, then rsp_err=1 and rsp_data=0x0E.
REQ-034 Build with ROWS=3, request addr=3 -> no word line ever high, rsp_valid after 1 cycle with rsp_err=1 and rsp_data=0.
REQ-035 Assert rst during ACCESS -> wl and wlb are 0 immediately, no rsp_valid, and req_ready=1 one cycle after release.
REQ-036 Random back-to-back traffic -> assertions for REQ-023 and REQ-024 hold, and req_wdata changes after acceptance never alter write_bit.
